par_rx_checker: RTL
===================

Name: par_rx_checker

Overview:
- Serial receiver and checker for the 8-bit even-parity scheme used by the team's parity generator.
- Deserialises a framed bit stream: start bit, DATA_W data bits LSB first, one parity bit, one stop bit.
- Recomputes parity over the received data and compares it with the received parity bit.
- Presents the captured byte with one-cycle valid, parity-error and framing-error pulses to the downstream consumer.

Parameters:
- DATA_W, 8, number of data bits per frame (valid range 1..16).
- ODD_PAR, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (inverted XOR).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_en  input  1  bit-slot strobe; ser_in is sampled only on edges where bit_en=1.
- ser_in  input  1  serial line, idle high.
- data_out  output  DATA_W  last completed frame's data; holds until the next frame completes.
- data_valid  output  1  one-cycle pulse, good frame completed.
- par_err  output  1  one-cycle pulse, parity mismatch on the completed frame.
- frame_err  output  1  one-cycle pulse, stop bit sampled as 0.
- busy  output  1  high while the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, bit counter=0, shift register=0, running parity=0.
  - data_out=0, data_valid=0, par_err=0, frame_err=0, busy=0.
- Reset mid-frame discards the partial frame; no pulses are generated for it.
- Edges with bit_en=0: the FSM, counter, shift register and running parity hold. data_valid, par_err and frame_err clear to 0.
- FSM on edges with bit_en=1:
  - IDLE: ser_in=0 -> DATA, counter=0, running parity=0. ser_in=1 -> stay in IDLE.
  - DATA: shift register bit[counter] <= ser_in; running parity ^= ser_in; counter increments. When counter==DATA_W-1 -> PARITY.
  - PARITY: store par_ok = (ser_in == running parity ^ ODD_PAR) -> STOP.
  - STOP: data_out <= shift register. par_err <= ~par_ok. If ser_in=1: data_valid<=1, frame_err<=0. If ser_in=0: data_valid<=0, frame_err<=1. -> IDLE.
- Pulses:
  - All pulse outputs are registered and high for exactly one clock, on the cycle after the stop-bit edge.
  - par_err is reported on framing-error frames too.
  - data_out updates on every completed frame, including errored ones.
- Latency: a full frame is DATA_W+3 enabled bit slots; outputs are valid 1 clk after the stop-bit sample.
- Back-to-back frames: a start bit may arrive in the first enabled slot after STOP. The pulse from the previous frame coincides with the IDLE sampling of that slot; both are handled without loss.
- busy is combinational from state: 0 only in IDLE.
- A start bit that is later contradicted is not re-validated; any 0 sampled in IDLE begins a frame.

Optional Feature:
- Macro PAR_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0].
  - Increments by 1 on every frame that raises par_err or frame_err; one frame with both errors counts once.
  - Saturates at 8'hFF.
  - Cleared by rst.
- Not defined: port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Good frame, even parity. Reset, then bit_en=1 every clk, frame 0,00000000,0,1 -> data_out=8'h00, data_valid=1 for 1 clk, par_err=0, frame_err=0.
- Parity error. Data 8'h01 sent with parity bit 0 -> data_out=8'h01, data_valid=1, par_err=1, frame_err=0. With PAR_ERR_CNT_EN, err_cnt=1.
- Framing error plus gaps. Data 8'hAA, parity 0, stop bit 0, bit_en high only every 3rd clk -> frame_err=1, data_valid=0, par_err=0, data_out=8'hAA. State must hold during bit_en=0.
- Reset mid-frame. Assert rst after 4 data bits of 8'hFF, then send a full good frame of 8'h3C -> no pulses for the first frame; the second gives data_out=8'h3C, data_valid=1, par_err=0.
- Back-to-back frames. Send 8'h55 then 8'h81 with no idle slot between them -> two data_valid pulses, data_out 8'h55 then 8'h81, no errors.
- Odd parity and saturation. With ODD_PAR=1, data 8'h00 and parity bit 1 -> par_err=0. With PAR_ERR_CNT_EN, 300 bad-parity frames -> err_cnt=8'hFF.

Source files
------------

// File: rtl/par_rx_checker.sv
// Framed serial receiver with parity and stop-bit checking (start, DATA_W bits LSB first, parity, stop).
// Optional saturating error counter output err_cnt enabled by defining PAR_ERR_CNT_EN.
module par_rx_checker #(
    parameter int DATA_W  = 8,
    parameter int ODD_PAR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              par_err,
    output logic              frame_err,
`ifdef PAR_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              busy
);

    localparam int   CNT_W   = $clog2(DATA_W + 1);
    localparam logic ODD_BIT = (ODD_PAR != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic              par_ok_q, par_ok_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
`ifdef PAR_ERR_CNT_EN
    logic [7:0]        ecnt_q, ecnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        par_d    = par_q;
        par_ok_d = par_ok_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
`ifdef PAR_ERR_CNT_EN
        ecnt_d   = ecnt_q;
`endif
        if (bit_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!ser_in) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                S_DATA: begin
                    // Compare-per-bit keeps the index width independent of DATA_W.
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i)) sh_d[i] = ser_in;
                    end
                    par_d = par_q ^ ser_in;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_ok_d = (ser_in == (par_q ^ ODD_BIT));
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    data_d  = sh_q;
                    perr_d  = ~par_ok_q;
                    valid_d = ser_in;
                    ferr_d  = ~ser_in;
                    state_d = S_IDLE;
`ifdef PAR_ERR_CNT_EN
                    if ((!par_ok_q || !ser_in) && (ecnt_q != 8'hFF)) ecnt_d = ecnt_q + 8'd1;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            par_ok_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef PAR_ERR_CNT_EN
            ecnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            par_ok_q <= par_ok_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
`ifdef PAR_ERR_CNT_EN
            ecnt_q   <= ecnt_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign par_err    = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);
`ifdef PAR_ERR_CNT_EN
    assign err_cnt    = ecnt_q;
`endif

endmodule
